id_ex_register: RTL and testbench
=================================

# id_ex_register

ID/EX pipeline register of the MIPS32 core. It captures the decode-stage bundle each cycle and presents it to the EX stage one cycle later: PC+4, both register operands, the 32-bit immediate from `extend`, the shift amount, the register addresses and the control word. It supports stall (hold) and flush (bubble insertion). It also has a write-back bypass, so the captured operands never hold stale register-file data, including while the stage is held by a stall.

## Interface
- `DATA_WIDTH`, 32, datapath width; also the width of the extended immediate.
- `REG_ADDR_WIDTH`, 5, register address width.
- `CTRL_WIDTH`, 18, width of the packed control word; field layout is defined in the shared package.

- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_stall`  in  1  hold the current contents.
- `i_flush`  in  1  insert a bubble.
- `i_valid`  in  1  the ID stage holds a real instruction.
- `i_pc_plus4`  in  DATA_WIDTH  PC+4 of the ID instruction.
- `i_rs_data`, `i_rt_data`  in  DATA_WIDTH  register-file read data.
- `i_ext_imm`  in  DATA_WIDTH  output of `extend`.
- `i_shamt`  in  5  instr[10:6].
- `i_rs_addr`, `i_rt_addr`, `i_rd_addr`  in  REG_ADDR_WIDTH  instruction register fields.
- `i_ctrl`  in  CTRL_WIDTH  control word from the decoder.
- `i_wb_write_en`  in  1  a write-back write is happening this cycle.
- `i_wb_addr`  in  REG_ADDR_WIDTH  write-back destination register.
- `i_wb_data`  in  DATA_WIDTH  write-back data.
- `o_valid`  out  1  the EX stage holds a real instruction.
- `o_pc_plus4`, `o_rs_data`, `o_rt_data`, `o_ext_imm`  out  DATA_WIDTH  registered copies of the corresponding inputs.
- `o_shamt`, `o_rs_addr`, `o_rt_addr`, `o_rd_addr`, `o_ctrl`  out  registered copies of the corresponding inputs.

## Operation
- Priority on each rising edge, highest first: reset > flush > stall > load.
- **Reset** (`i_rst_n`=0): every output goes to 0, including `o_valid` and `o_ctrl`.
- **Flush**:
  - `o_valid`←0 and `o_ctrl`←0, giving a bubble with no side effects downstream.
  - All data and address outputs hold their values.
  - Flush overrides a simultaneous stall.
- **Stall**:
  - All outputs hold, with one exception: if `o_valid`=1, `i_wb_write_en`=1, `i_wb_addr`≠0 and `i_wb_addr`==`o_rs_addr`, then `o_rs_data`←`i_wb_data`.
  - The same rule applies independently to `o_rt_addr`/`o_rt_data`.
- **Load**:
  - All fields capture their inputs.
  - `o_valid`←`i_valid`.
  - `o_ctrl`←`i_valid` ? `i_ctrl` : 0.
  - Operand bypass: if `i_wb_write_en`=1, `i_wb_addr`≠0 and `i_wb_addr`==`i_rs_addr`, then `o_rs_data`←`i_wb_data`; otherwise `o_rs_data`←`i_rs_data`. The same rule applies to rt.
- Register 0 is never bypassed.
- No arithmetic is performed. All fields pass through at full width; `i_ext_imm` is not re-extended.

## Timing
- Latency is 1 cycle: inputs present at edge N appear on the outputs after edge N.
- Outputs are driven directly from flops. There is no combinational path from input to output.
- A stall of any length keeps `o_ctrl` and `o_valid` stable; only the bypass rule can change operand data during a stall.
- Reset deasserted mid-stream: the first edge with `i_rst_n`=1 performs a normal load or flush, according to the priority above.
- Flush and WB write in the same cycle: no operand update is required, because `o_valid`=0 afterwards.
- WB write to rs and rt when they are the same register: both operands are updated.

## Structure
- Shared package `mips_pkg`:
  - control-word field indices: `REG_WRITE`, `MEM_READ`, `MEM_WRITE`, `MEM_TO_REG`, `ALU_SRC`, `REG_DST`, `ALU_OP` (4-bit), `BRANCH`, `JUMP`, `SIGNED_IMM`, etc., totalling `CTRL_WIDTH`;
  - `CTRL_NOP` = 0;
  - `REG_ZERO` = 0.
- Sub-module `operand_bypass`: a combinational compare-and-select on (write enable, WB address, WB data, operand address, operand data). It is instantiated four times: rs and rt on the load path, rs and rt on the stall path.

## Test plan
- Reset: hold `i_rst_n`=0 with random inputs, then release → all outputs 0 during reset; the first load after release captures the inputs, e.g. `o_ext_imm`=0xFFFF8000 for `i_ext_imm`=0xFFFF8000.
- Plain load: `i_valid`=1, `i_rs_data`=0x11, `i_ctrl`=0x2A5 → next cycle `o_rs_data`=0x11, `o_ctrl`=0x2A5, `o_valid`=1.
- Flush during stall: `i_stall`=1, `i_flush`=1 → `o_valid`=0, `o_ctrl`=0, `o_pc_plus4` unchanged.
- Load bypass: `i_rs_addr`=8, `i_rs_data`=0x1, WB writes r8=0xBEEF → `o_rs_data`=0xBEEF; repeat with address 0 → `o_rs_data`=`i_rs_data`.
- Stall bypass: hold 3 cycles with `o_rt_addr`=9; WB writes r9=0xCAFE in the 2nd cycle → `o_rt_data`=0xCAFE from the 3rd cycle; `o_ctrl` stays constant throughout.
- Invalid input: `i_valid`=0, `i_ctrl`=0x3FFFF → `o_ctrl`=0, `o_valid`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS32 pipeline.
//   - Datapath and register-address widths.
//   - Bit positions of the packed control word produced by the decoder.
//   - CTRL_NOP: the all-zero control word. A bubble carrying it has no
//     architectural side effects.
//   - REG_ZERO: the hard-wired zero register, which is never a bypass target.
//   - bypass_hit: shared compare used by the operand bypass.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CTRL_WIDTH     = 18;

    // Control word field positions (bit indices into the CTRL_WIDTH vector)
    localparam int REG_WRITE   = 0;
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 2;
    localparam int MEM_TO_REG  = 3;
    localparam int ALU_SRC     = 4;
    localparam int REG_DST     = 5;
    localparam int ALU_OP_LSB  = 6;   // ALU_OP occupies [9:6]
    localparam int ALU_OP_MSB  = 9;
    localparam int BRANCH      = 10;
    localparam int JUMP        = 11;
    localparam int SIGNED_IMM  = 12;
    localparam int BRANCH_NE   = 13;
    localparam int JUMP_REG    = 14;
    localparam int LINK        = 15;
    localparam int SHIFT_VAR   = 16;
    localparam int MEM_BYTE    = 17;

    localparam logic [CTRL_WIDTH-1:0]     CTRL_NOP = {CTRL_WIDTH{1'b0}};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    // True when a write-back to wb_addr must replace the operand read from
    // op_addr. Writes to the zero register are ignored.
    function automatic logic bypass_hit(
        input logic                      write_en,
        input logic [REG_ADDR_WIDTH-1:0] wb_addr,
        input logic [REG_ADDR_WIDTH-1:0] op_addr
    );
        return write_en && (wb_addr != REG_ZERO) && (wb_addr == op_addr);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: combinational compare-and-select for one register operand.
//
// When a write-back is targeting the operand's register in the same cycle,
// this block substitutes the write-back data for the (now stale) operand.
//   i_wb_write_en  write-back write active. The caller gates this input as
//                  needed, for example with o_valid on the stall path.
//   i_wb_addr      write-back destination register.
//   i_wb_data      write-back data.
//   i_op_addr      operand register address.
//   i_op_data      operand data as currently known.
//   o_op_data      operand data after the bypass.
module operand_bypass
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_wb_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_op_addr,
    input  logic [DATA_WIDTH-1:0]     i_op_data,
    output logic [DATA_WIDTH-1:0]     o_op_data
);

    logic hit_s;

    // Select the write-back data when it targets this operand's register.
    always_comb begin
        hit_s     = bypass_hit(i_wb_write_en, i_wb_addr, i_op_addr);
        o_op_data = i_op_data;
        if (hit_s) begin
            o_op_data = i_wb_data;
        end else begin
            o_op_data = i_op_data;
        end
    end

endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register of the MIPS32 core.
//
// Captures the decode bundle on each rising edge and presents it to EX one
// cycle later. Every output is driven directly by a flop.
//
// Edge priority: reset > flush > stall > load.
//   reset  Synchronous, active-low. Clears every output.
//   flush  Clears o_valid and o_ctrl to make a bubble. Data and address
//          outputs hold.
//   stall  Holds everything, except that a write-back to a held source
//          register of a valid instruction refreshes that operand.
//   load   Captures the inputs. Operands are bypassed from the write-back
//          port so that the captured data is never stale.
//
// Ports
//   i_clk, i_rst_n, i_stall, i_flush     clock, reset, pipeline control
//   i_valid, i_pc_plus4, i_rs_data, i_rt_data, i_ext_imm, i_shamt,
//   i_rs_addr, i_rt_addr, i_rd_addr, i_ctrl      ID-stage bundle
//   i_wb_write_en, i_wb_addr, i_wb_data          write-back port
//   o_*                                          registered EX-stage bundle
module id_ex_register
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 18
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     i_rs_data,
    input  logic [DATA_WIDTH-1:0]     i_rt_data,
    input  logic [DATA_WIDTH-1:0]     i_ext_imm,
    input  logic [4:0]                i_shamt,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [CTRL_WIDTH-1:0]     i_ctrl,
    input  logic                      i_wb_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_pc_plus4,
    output logic [DATA_WIDTH-1:0]     o_rs_data,
    output logic [DATA_WIDTH-1:0]     o_rt_data,
    output logic [DATA_WIDTH-1:0]     o_ext_imm,
    output logic [4:0]                o_shamt,
    output logic [REG_ADDR_WIDTH-1:0] o_rs_addr,
    output logic [REG_ADDR_WIDTH-1:0] o_rt_addr,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    output logic [CTRL_WIDTH-1:0]     o_ctrl
);

    logic                      valid_r;
    logic [DATA_WIDTH-1:0]     pc_plus4_r;
    logic [DATA_WIDTH-1:0]     rs_data_r;
    logic [DATA_WIDTH-1:0]     rt_data_r;
    logic [DATA_WIDTH-1:0]     ext_imm_r;
    logic [4:0]                shamt_r;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_r;
    logic [REG_ADDR_WIDTH-1:0] rt_addr_r;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
    logic [CTRL_WIDTH-1:0]     ctrl_r;

    logic [DATA_WIDTH-1:0]     load_rs_s;
    logic [DATA_WIDTH-1:0]     load_rt_s;
    logic [DATA_WIDTH-1:0]     stall_rs_s;
    logic [DATA_WIDTH-1:0]     stall_rt_s;
    logic                      stall_wb_en_s;
    logic [CTRL_WIDTH-1:0]     load_ctrl_s;

    // A held bubble carries no live operands, so it is not refreshed.
    assign stall_wb_en_s = i_wb_write_en & valid_r;

    // An invalid ID slot enters EX with a NOP control word.
    always_comb begin
        load_ctrl_s = CTRL_WIDTH'(CTRL_NOP);
        if (i_valid) begin
            load_ctrl_s = i_ctrl;
        end else begin
            load_ctrl_s = CTRL_WIDTH'(CTRL_NOP);
        end
    end

    operand_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_rs_bypass (
        .i_wb_write_en (i_wb_write_en),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_op_addr     (i_rs_addr),
        .i_op_data     (i_rs_data),
        .o_op_data     (load_rs_s)
    );

    operand_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_rt_bypass (
        .i_wb_write_en (i_wb_write_en),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_op_addr     (i_rt_addr),
        .i_op_data     (i_rt_data),
        .o_op_data     (load_rt_s)
    );

    operand_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_stall_rs_bypass (
        .i_wb_write_en (stall_wb_en_s),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_op_addr     (rs_addr_r),
        .i_op_data     (rs_data_r),
        .o_op_data     (stall_rs_s)
    );

    operand_bypass #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_stall_rt_bypass (
        .i_wb_write_en (stall_wb_en_s),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .i_op_addr     (rt_addr_r),
        .i_op_data     (rt_data_r),
        .o_op_data     (stall_rt_s)
    );

    // Pipeline register: reset > flush > stall > load.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r    <= 1'b0;
            pc_plus4_r <= {DATA_WIDTH{1'b0}};
            rs_data_r  <= {DATA_WIDTH{1'b0}};
            rt_data_r  <= {DATA_WIDTH{1'b0}};
            ext_imm_r  <= {DATA_WIDTH{1'b0}};
            shamt_r    <= 5'd0;
            rs_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            rt_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            rd_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            ctrl_r     <= CTRL_WIDTH'(CTRL_NOP);
        end else if (i_flush) begin
            // The bubble is defined by valid/ctrl alone. Data fields hold, so
            // a flush does not toggle the wide datapath.
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_WIDTH'(CTRL_NOP);
        end else if (i_stall) begin
            rs_data_r <= stall_rs_s;
            rt_data_r <= stall_rt_s;
        end else begin
            valid_r    <= i_valid;
            pc_plus4_r <= i_pc_plus4;
            rs_data_r  <= load_rs_s;
            rt_data_r  <= load_rt_s;
            ext_imm_r  <= i_ext_imm;
            shamt_r    <= i_shamt;
            rs_addr_r  <= i_rs_addr;
            rt_addr_r  <= i_rt_addr;
            rd_addr_r  <= i_rd_addr;
            ctrl_r     <= load_ctrl_s;
        end
    end

    assign o_valid    = valid_r;
    assign o_pc_plus4 = pc_plus4_r;
    assign o_rs_data  = rs_data_r;
    assign o_rt_data  = rt_data_r;
    assign o_ext_imm  = ext_imm_r;
    assign o_shamt    = shamt_r;
    assign o_rs_addr  = rs_addr_r;
    assign o_rt_addr  = rt_addr_r;
    assign o_rd_addr  = rd_addr_r;
    assign o_ctrl     = ctrl_r;

endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed, table-driven bench for id_ex_register.
// Each table row applies one cycle of inputs. After the rising edge, every
// output is compared against values computed by hand.
module tb_id_ex_register;

    logic        clk_s = 1'b0;
    logic        rst_n_s, stall_s, flush_s, valid_s;
    logic [31:0] pc_s, rs_s, rt_s, imm_s;
    logic [4:0]  sh_s, rsa_s, rta_s, rda_s;
    logic [17:0] ctrl_s;
    logic        we_s;
    logic [4:0]  wa_s;
    logic [31:0] wd_s;

    logic        o_valid_s;
    logic [31:0] o_pc_s, o_rs_s, o_rt_s, o_imm_s;
    logic [4:0]  o_sh_s, o_rsa_s, o_rta_s, o_rda_s;
    logic [17:0] o_ctrl_s;

    int checks_r   = 0;
    int failures_r = 0;

    typedef struct {
        logic        rst_n, stall, flush, valid;
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  sh, rsa, rta, rda;
        logic [17:0] ctrl;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_valid;
        logic [31:0] e_pc, e_rs, e_rt, e_imm;
        logic [4:0]  e_sh, e_rsa, e_rta, e_rda;
        logic [17:0] e_ctrl;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    id_ex_register dut (
        .i_clk         (clk_s),
        .i_rst_n       (rst_n_s),
        .i_stall       (stall_s),
        .i_flush       (flush_s),
        .i_valid       (valid_s),
        .i_pc_plus4    (pc_s),
        .i_rs_data     (rs_s),
        .i_rt_data     (rt_s),
        .i_ext_imm     (imm_s),
        .i_shamt       (sh_s),
        .i_rs_addr     (rsa_s),
        .i_rt_addr     (rta_s),
        .i_rd_addr     (rda_s),
        .i_ctrl        (ctrl_s),
        .i_wb_write_en (we_s),
        .i_wb_addr     (wa_s),
        .i_wb_data     (wd_s),
        .o_valid       (o_valid_s),
        .o_pc_plus4    (o_pc_s),
        .o_rs_data     (o_rs_s),
        .o_rt_data     (o_rt_s),
        .o_ext_imm     (o_imm_s),
        .o_shamt       (o_sh_s),
        .o_rs_addr     (o_rsa_s),
        .o_rt_addr     (o_rta_s),
        .o_rd_addr     (o_rda_s),
        .o_ctrl        (o_ctrl_s)
    );

    // Free-running clock, period 10.
    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, "_valid"}, {31'd0, o_valid_s}, {31'd0, v.e_valid});
        chk({tag, "_pc"},    o_pc_s,   v.e_pc);
        chk({tag, "_rs"},    o_rs_s,   v.e_rs);
        chk({tag, "_rt"},    o_rt_s,   v.e_rt);
        chk({tag, "_imm"},   o_imm_s,  v.e_imm);
        chk({tag, "_sh"},    {27'd0, o_sh_s},  {27'd0, v.e_sh});
        chk({tag, "_rsa"},   {27'd0, o_rsa_s}, {27'd0, v.e_rsa});
        chk({tag, "_rta"},   {27'd0, o_rta_s}, {27'd0, v.e_rta});
        chk({tag, "_rda"},   {27'd0, o_rda_s}, {27'd0, v.e_rda});
        chk({tag, "_ctrl"},  {14'd0, o_ctrl_s}, {14'd0, v.e_ctrl});
    endtask

    task automatic drive(input vec_t v);
        rst_n_s = v.rst_n; stall_s = v.stall; flush_s = v.flush; valid_s = v.valid;
        pc_s = v.pc; rs_s = v.rs; rt_s = v.rt; imm_s = v.imm;
        sh_s = v.sh; rsa_s = v.rsa; rta_s = v.rta; rda_s = v.rda;
        ctrl_s = v.ctrl; we_s = v.we; wa_s = v.wa; wd_s = v.wd;
    endtask

    initial begin
        vec_t zero_v;
        vec_t ctrl_ref;

        // Columns: rst,stall,flush,valid, pc,rs,rt,imm, sh,rsa,rta,rda, ctrl, we,wa,wd |
        //          e_valid, e_pc,e_rs,e_rt,e_imm, e_sh,e_rsa,e_rta,e_rda, e_ctrl
        // 0: first load after reset, sign-extended immediate
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b1, 32'h104,32'h11,32'h22,32'hFFFF8000, 5'd3,5'd1,5'd2,5'd3, 18'h2A5, 1'b0,5'd0,32'h0,
                     1'b1, 32'h104,32'h11,32'h22,32'hFFFF8000, 5'd3,5'd1,5'd2,5'd3, 18'h2A5};
        // 1: load bypass rs (r8 <- BEEF)
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1, 32'h108,32'h1,32'h5,32'h7FFF, 5'd0,5'd8,5'd9,5'd10, 18'h0F0, 1'b1,5'd8,32'hBEEF,
                     1'b1, 32'h108,32'hBEEF,32'h5,32'h7FFF, 5'd0,5'd8,5'd9,5'd10, 18'h0F0};
        // 2: write-back to r0 is never bypassed
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 32'h10C,32'h1,32'h6,32'h10, 5'd31,5'd0,5'd0,5'd0, 18'h003, 1'b1,5'd0,32'hDEAD,
                     1'b1, 32'h10C,32'h1,32'h6,32'h10, 5'd31,5'd0,5'd0,5'd0, 18'h003};
        // 3: rs == rt == wb register, both bypassed
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1, 32'h110,32'hA,32'hB,32'h20, 5'd1,5'd9,5'd9,5'd4, 18'h001, 1'b1,5'd9,32'h1234,
                     1'b1, 32'h110,32'h1234,32'h1234,32'h20, 5'd1,5'd9,5'd9,5'd4, 18'h001};
        // 4: address match but write enable low
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1, 32'h114,32'hAA,32'hBB,32'h30, 5'd2,5'd5,5'd6,5'd7, 18'h012, 1'b0,5'd5,32'h999,
                     1'b1, 32'h114,32'hAA,32'hBB,32'h30, 5'd2,5'd5,5'd6,5'd7, 18'h012};
        // 5: load the instruction that will be stalled (rt = r9)
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b1, 32'h118,32'h100,32'h200,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155, 1'b0,5'd0,32'h0,
                     1'b1, 32'h118,32'h100,32'h200,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155};
        // 6: stall 1; wb to r13 matches the input rt only, not the held rt
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b1,5'd13,32'h5555,
                     1'b1, 32'h118,32'h100,32'h200,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155};
        // 7: stall 2; wb r9 <- CAFE updates the held rt
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b1,5'd9,32'hCAFE,
                     1'b1, 32'h118,32'h100,32'hCAFE,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155};
        // 8: stall 3; no write-back
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b0,5'd9,32'h0,
                     1'b1, 32'h118,32'h100,32'hCAFE,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155};
        // 9: stall 4; wb r3 updates the held rs
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b1,5'd3,32'h3333,
                     1'b1, 32'h118,32'h3333,32'hCAFE,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h155};
        // 10: flush wins over stall; data holds, no operand update
        vecs[10] = '{1'b1,1'b1,1'b1,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b1,5'd3,32'h4444,
                     1'b0, 32'h118,32'h3333,32'hCAFE,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h0};
        // 11: stalled bubble ignores a matching write-back
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1, 32'hFFF0,32'h777,32'h888,32'h1, 5'd7,5'd12,5'd13,5'd14, 18'h3FFFF, 1'b1,5'd9,32'h6666,
                     1'b0, 32'h118,32'h3333,32'hCAFE,32'h40, 5'd4,5'd3,5'd9,5'd11, 18'h0};
        // 12: invalid input gives ctrl 0 and valid 0; data captured
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 32'h200,32'h21,32'h22,32'h5, 5'd5,5'd6,5'd7,5'd8, 18'h3FFFF, 1'b0,5'd0,32'h0,
                     1'b0, 32'h200,32'h21,32'h22,32'h5, 5'd5,5'd6,5'd7,5'd8, 18'h0};
        // 13: valid load with all-ones control and immediate
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1, 32'h204,32'h31,32'h32,32'hFFFFFFFF, 5'd6,5'd10,5'd11,5'd12, 18'h3FFFF, 1'b0,5'd0,32'h0,
                     1'b1, 32'h204,32'h31,32'h32,32'hFFFFFFFF, 5'd6,5'd10,5'd11,5'd12, 18'h3FFFF};
        // 14: flush alone with a wb hit on the held rs
        vecs[14] = '{1'b1,1'b0,1'b1,1'b1, 32'h300,32'h41,32'h42,32'h9, 5'd9,5'd10,5'd11,5'd13, 18'h001, 1'b1,5'd10,32'h7777,
                     1'b0, 32'h204,32'h31,32'h32,32'hFFFFFFFF, 5'd6,5'd10,5'd11,5'd12, 18'h0};
        // 15: reset mid-stream
        vecs[15] = '{1'b0,1'b0,1'b0,1'b1, 32'h300,32'h41,32'h42,32'h9, 5'd9,5'd10,5'd11,5'd13, 18'h001, 1'b1,5'd10,32'h7777,
                     1'b0, 32'h0,32'h0,32'h0,32'h0, 5'd0,5'd0,5'd0,5'd0, 18'h0};
        // 16: first edge after release is a flush
        vecs[16] = '{1'b1,1'b0,1'b1,1'b1, 32'h300,32'h41,32'h42,32'h9, 5'd9,5'd10,5'd11,5'd13, 18'h001, 1'b1,5'd10,32'h7777,
                     1'b0, 32'h0,32'h0,32'h0,32'h0, 5'd0,5'd0,5'd0,5'd0, 18'h0};
        // 17: load with rt bypass at top register addresses
        vecs[17] = '{1'b1,1'b0,1'b0,1'b1, 32'h400,32'h51,32'h52,32'h8000, 5'd10,5'd31,5'd30,5'd29, 18'h20000, 1'b1,5'd30,32'hABCD,
                     1'b1, 32'h400,32'h51,32'hABCD,32'h8000, 5'd10,5'd31,5'd30,5'd29, 18'h20000};

        zero_v = vecs[15];

        // Hold reset with random inputs; every output must read 0.
        for (int c = 0; c < 3; c++) begin
            rst_n_s = 1'b0; stall_s = 1'($urandom); flush_s = 1'($urandom); valid_s = 1'($urandom);
            pc_s = $urandom; rs_s = $urandom; rt_s = $urandom; imm_s = $urandom;
            sh_s = 5'($urandom); rsa_s = 5'($urandom); rta_s = 5'($urandom); rda_s = 5'($urandom);
            ctrl_s = 18'($urandom); we_s = 1'($urandom); wa_s = 5'($urandom); wd_s = $urandom;
            @(posedge clk_s); #1;
            check_outputs($sformatf("reset%0d", c), zero_v);
            @(negedge clk_s);
        end

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk_s); #1;
            check_outputs($sformatf("row%0d", i), vecs[i]);
            @(negedge clk_s);
        end

        // Long stall: ctrl/valid stay fixed for 6 cycles while inputs change.
        ctrl_ref = vecs[17];
        for (int c = 0; c < 6; c++) begin
            rst_n_s = 1'b1; stall_s = 1'b1; flush_s = 1'b0; valid_s = 1'b1;
            pc_s = $urandom; rs_s = $urandom; rt_s = $urandom; imm_s = $urandom;
            sh_s = 5'($urandom); rsa_s = 5'($urandom); rta_s = 5'($urandom); rda_s = 5'($urandom);
            ctrl_s = 18'($urandom); we_s = 1'b0; wa_s = 5'd0; wd_s = $urandom;
            @(posedge clk_s); #1;
            check_outputs($sformatf("longstall%0d", c), ctrl_ref);
            @(negedge clk_s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
